// File: rtl/cipher_stream_out.sv
// cipher_stream_out: buffers 64-bit ciphertext blocks in a small FIFO and
// serializes them MSB-first as a byte stream with valid/ready handshake.
module cipher_stream_out #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_cipher,
  input  logic [63:0] cipher_block_i,
  input  logic        last_block_i,
  output logic [7:0]  byte_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        last_o,
  output logic        full_o,
  output logic        empty_o,
  output logic        overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_nxt;
  logic [64:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [63:0]   shifter;
  logic          last_q;
  logic [2:0]    byte_idx;
  logic          overflow;
  logic          fifo_ne, is_full, wr_en, pop, xfer;

  assign fifo_ne = (count != '0);
  assign is_full = (count == DEPTH_C);
  // A block arriving while full is dropped even if a pop frees a slot on the
  // same edge: acceptance is decided on the pre-edge occupancy only.
  assign wr_en   = en_cipher && !is_full;
  assign xfer    = (state == SHIFT) && ready_i;

  // Next-state: load from FIFO when idle, or chain the next block on the last byte
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: if (fifo_ne) begin
        pop       = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: if (xfer && byte_idx == 3'd7) begin
        if (fifo_ne) pop       = 1'b1;
        else         state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FIFO storage: {last flag, block}; contents need no reset, pointers gate them
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {last_block_i, cipher_block_i};
  end

  // Pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (en_cipher && is_full) overflow <= 1'b1;
    end
  end

  // Shifter: a load takes priority over the shift of the outgoing last byte
  always_ff @(posedge clk) begin
    if (reset) begin
      shifter  <= '0;
      last_q   <= 1'b0;
      byte_idx <= '0;
    end else if (pop) begin
      shifter  <= mem[rd_ptr][63:0];
      last_q   <= mem[rd_ptr][64];
      byte_idx <= '0;
    end else if (xfer) begin
      shifter  <= {shifter[55:0], 8'h00};
      byte_idx <= byte_idx + 1'b1;
    end
  end

  assign valid_o    = (state == SHIFT);
  assign byte_o     = valid_o ? shifter[63:56] : 8'h00;
  assign last_o     = valid_o && (byte_idx == 3'd7) && last_q;
  assign full_o     = is_full;
  assign empty_o    = !fifo_ne && (state == IDLE);
  assign overflow_o = overflow;

endmodule

// File: tb/tb_cipher_stream_out.sv
// Self-checking bench for cipher_stream_out: random blocks are turned into an
// expected byte stream (MSB first, last flag on byte 7) and compared on transfer.
module tb_cipher_stream_out;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, en_cipher, last_block_i, ready_i;
  logic [63:0] cipher_block_i;
  logic [7:0]  byte_o;
  logic        valid_o, last_o, full_o, empty_o, overflow_o;

  int errs = 0, checks = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  cipher_stream_out #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .en_cipher(en_cipher),
    .cipher_block_i(cipher_block_i), .last_block_i(last_block_i),
    .byte_o(byte_o), .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o),
    .full_o(full_o), .empty_o(empty_o), .overflow_o(overflow_o)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Reference model: a block becomes 8 bytes, big-endian, last flag on byte 7.
  function automatic void push_block(logic [63:0] b, logic l);
    for (int i = 0; i < 8; i++) exp_q.push_back({l && (i == 7), b[63-8*i -: 8]});
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic strobe(logic [63:0] b, logic l);
    en_cipher = 1'b1; cipher_block_i = b; last_block_i = l;
    step();
    en_cipher = 1'b0;
  endtask

  function automatic logic [8:0] next_exp();
    if (exp_q.size() == 0) return 9'h1ff;
    return exp_q.pop_front();
  endfunction

  task automatic do_reset();
    reset = 1'b1; en_cipher = 1'b0; ready_i = 1'b0;
    step(); step();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({byte_o, valid_o, last_o, full_o, empty_o, overflow_o} !== {8'h00, 5'b00010}) begin
      errs++;
      $display("FAIL reset_state: byte=%h v=%b l=%b full=%b empty=%b ovf=%b want 00 0 0 0 1 0",
               byte_o, valid_o, last_o, full_o, empty_o, overflow_o);
    end
  endtask

  task automatic test_single();
    logic [8:0] e;
    ready_i = 1'b1;
    push_block(64'h0123456789ABCDEF, 1'b1);
    strobe(64'h0123456789ABCDEF, 1'b1);
    checks++;
    if (valid_o !== 1'b0 || empty_o !== 1'b0) begin
      errs++; $display("FAIL single_capture: valid=%b empty=%b want 0 0", valid_o, empty_o);
    end
    step();
    for (int n = 0; n < 8; n++) begin
      e = next_exp(); checks++;
      if (valid_o !== 1'b1 || {last_o, byte_o} !== e) begin
        errs++; $display("FAIL single_byte%0d: v=%b last=%b byte=%h want v=1 last=%b byte=%h",
                         n, valid_o, last_o, byte_o, e[8], e[7:0]);
      end
      step();
    end
    checks++;
    if (valid_o !== 1'b0 || empty_o !== 1'b1 || last_o !== 1'b0) begin
      errs++; $display("FAIL single_end: valid=%b empty=%b last=%b want 0 1 0", valid_o, empty_o, last_o);
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] e;
    logic [63:0] b;
    int xfers = 0, wait_cyc = 0;
    ready_i = 1'b0;
    b = rnd64();
    push_block(b, 1'b0);
    strobe(b, 1'b0);
    while (!valid_o && wait_cyc < 10) begin step(); wait_cyc++; end
    checks++;
    if (!valid_o) begin errs++; $display("FAIL bp_timeout: valid=%b want 1", valid_o); end
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (valid_o !== 1'b1 || byte_o !== exp_q[0][7:0] || last_o !== 1'b0) begin
        errs++; $display("FAIL bp_hold%0d: v=%b byte=%h last=%b want 1 %h 0",
                         n, valid_o, byte_o, last_o, exp_q[0][7:0]);
      end
      step();
    end
    ready_i = 1'b1;
    for (int n = 0; n < 12; n++) begin
      if (valid_o) begin
        e = next_exp(); xfers++; checks++;
        if ({last_o, byte_o} !== e) begin
          errs++; $display("FAIL bp_byte%0d: last=%b byte=%h want %b %h", xfers, last_o, byte_o, e[8], e[7:0]);
        end
      end
      step();
    end
    checks++;
    if (xfers != 8 || exp_q.size() != 0) begin
      errs++; $display("FAIL bp_count: transfers=%0d left=%0d want 8 0", xfers, exp_q.size());
    end
  endtask

  task automatic test_overflow();
    logic [8:0] e;
    logic [63:0] b;
    ready_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      b = rnd64() ^ 64'(k);
      push_block(b, k == 5);
      strobe(b, k == 5);
    end
    checks++;
    if (full_o !== 1'b1 || overflow_o !== 1'b0) begin
      errs++; $display("FAIL ovf_fill: full=%b ovf=%b want 1 0", full_o, overflow_o);
    end
    strobe(rnd64(), 1'b1);
    checks++;
    if (overflow_o !== 1'b1 || full_o !== 1'b1) begin
      errs++; $display("FAIL ovf_flag: ovf=%b full=%b want 1 1", overflow_o, full_o);
    end
    ready_i = 1'b1;
    for (int n = 0; n < 40; n++) begin
      e = next_exp(); checks++;
      if (valid_o !== 1'b1 || {last_o, byte_o} !== e) begin
        errs++; $display("FAIL ovf_byte%0d: v=%b last=%b byte=%h want 1 %b %h",
                         n, valid_o, last_o, byte_o, e[8], e[7:0]);
      end
      step();
    end
    step();
    checks++;
    if (valid_o !== 1'b0 || empty_o !== 1'b1 || overflow_o !== 1'b1) begin
      errs++; $display("FAIL ovf_end: valid=%b empty=%b ovf=%b want 0 1 1", valid_o, empty_o, overflow_o);
    end
    do_reset();
    checks++;
    if (overflow_o !== 1'b0) begin errs++; $display("FAIL ovf_clear: ovf=%b want 0", overflow_o); end
  endtask

  task automatic test_back_to_back();
    int nb = 2*DEPTH + 2;
    ready_i = 1'b1;
    fork
      begin : producer
        logic [63:0] b;
        logic l;
        int sent = 0, guard = 0;
        while (sent < nb && guard < 500) begin
          if (!full_o) begin
            b = rnd64(); l = 1'($urandom_range(0, 1));
            push_block(b, l);
            en_cipher = 1'b1; cipher_block_i = b; last_block_i = l;
            sent++;
          end else en_cipher = 1'b0;
          step(); guard++;
        end
        en_cipher = 1'b0;
      end
      begin : consumer
        logic [8:0] e;
        int w = 0;
        while (!valid_o && w < 10) begin step(); w++; end
        for (int n = 0; n < nb*8; n++) begin
          e = next_exp(); checks++;
          if (valid_o !== 1'b1 || {last_o, byte_o} !== e) begin
            errs++; $display("FAIL b2b_byte%0d: v=%b last=%b byte=%h want 1 %b %h",
                             n, valid_o, last_o, byte_o, e[8], e[7:0]);
          end
          step();
        end
      end
    join
    checks++;
    if (valid_o !== 1'b0 || empty_o !== 1'b1 || exp_q.size() != 0) begin
      errs++; $display("FAIL b2b_end: valid=%b empty=%b left=%0d want 0 1 0", valid_o, empty_o, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] e;
    logic [63:0] b;
    ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      b = rnd64(); push_block(b, 1'b1); strobe(b, 1'b1);
    end
    ready_i = 1'b1;
    for (int n = 0; n < 4; n++) begin
      e = next_exp(); checks++;
      if (valid_o !== 1'b1 || {last_o, byte_o} !== e) begin
        errs++; $display("FAIL rmid_pre%0d: v=%b byte=%h want 1 %h", n, valid_o, byte_o, e[7:0]);
      end
      step();
    end
    reset = 1'b1; step(); reset = 1'b0;
    exp_q.delete();
    checks++;
    if (valid_o !== 1'b0 || empty_o !== 1'b1) begin
      errs++; $display("FAIL rmid_after: valid=%b empty=%b want 0 1", valid_o, empty_o);
    end
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (valid_o !== 1'b0) begin errs++; $display("FAIL rmid_stale%0d: valid=%b want 0", n, valid_o); end
      step();
    end
    b = rnd64(); push_block(b, 1'b0); strobe(b, 1'b0);
    step();
    for (int n = 0; n < 8; n++) begin
      e = next_exp(); checks++;
      if (valid_o !== 1'b1 || {last_o, byte_o} !== e) begin
        errs++; $display("FAIL rmid_new%0d: v=%b last=%b byte=%h want 1 %b %h",
                         n, valid_o, last_o, byte_o, e[8], e[7:0]);
      end
      step();
    end
  endtask

  task automatic test_same_edge_full();
    logic [8:0] e;
    logic [63:0] b;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      b = rnd64(); push_block(b, 1'b1); strobe(b, 1'b1);
    end
    checks++;
    if (full_o !== 1'b1) begin errs++; $display("FAIL sef_fill: full=%b want 1", full_o); end
    ready_i = 1'b1;
    for (int n = 0; n < 8; n++) begin
      e = next_exp(); checks++;
      if (valid_o !== 1'b1 || {last_o, byte_o} !== e) begin
        errs++; $display("FAIL sef_first%0d: v=%b last=%b byte=%h want 1 %b %h",
                         n, valid_o, last_o, byte_o, e[8], e[7:0]);
      end
      if (n == 7) begin en_cipher = 1'b1; cipher_block_i = rnd64(); last_block_i = 1'b0; end
      step();
      en_cipher = 1'b0;
    end
    checks++;
    if (overflow_o !== 1'b1 || full_o !== 1'b0) begin
      errs++; $display("FAIL sef_drop: ovf=%b full=%b want 1 0", overflow_o, full_o);
    end
    for (int n = 0; n < 32; n++) begin
      e = next_exp(); checks++;
      if (valid_o !== 1'b1 || {last_o, byte_o} !== e) begin
        errs++; $display("FAIL sef_rest%0d: v=%b last=%b byte=%h want 1 %b %h",
                         n, valid_o, last_o, byte_o, e[8], e[7:0]);
      end
      step();
    end
    checks++;
    if (valid_o !== 1'b0 || empty_o !== 1'b1) begin
      errs++; $display("FAIL sef_end: valid=%b empty=%b want 0 1", valid_o, empty_o);
    end
  endtask

  initial begin
    reset = 1'b1; en_cipher = 1'b0; ready_i = 1'b0;
    cipher_block_i = '0; last_block_i = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_same_edge_full();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
